// File: rtl/codec_seq_pkg.sv
// Shared types and default timing for the codec bring-up sequencer.
// Optional feature macro: LRCK_WATCHDOG_EN (ADC LRCK activity watchdog in RUN).
package codec_seq_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned RETRY_W = 2;

    // Default cycle counts at 12.288 MHz
    localparam int unsigned DEF_PWRUP_CYC   = 327680;
    localparam int unsigned DEF_CFG_TO_CYC  = 1048575;
    localparam int unsigned DEF_SETTLE_CYC  = 65536;
    localparam int unsigned DEF_LRCK_TO_CYC = 4096;
    localparam int unsigned DEF_MAX_RETRY   = 3;
    localparam int unsigned DEF_CNT_W       = 20;

    typedef enum logic [STATE_W-1:0] {
        ST_HOLD    = 3'd0,
        ST_ADC_CFG = 3'd1,
        ST_DAC_CFG = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_RUN     = 3'd4,
        ST_FAULT   = 3'd5
    } seq_state_t;

    // True while another attempt is allowed after 'fails' failures
    function automatic logic retry_left(input logic [RETRY_W-1:0] fails,
                                        input int unsigned        max_retry);
        return (32'(fails) + 32'd1) < max_retry;
    endfunction

endpackage

// File: rtl/codec_init_sequencer_lrck_mon.sv
// ADC LRCK activity monitor: 2-FF synchroniser, edge detect and a
// no-edge watchdog that fires after LRCK_TO_CYC quiet clocks while enabled.
module lrck_activity_mon
    import codec_seq_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned LRCK_TO_CYC = DEF_LRCK_TO_CYC
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_lrck,
    output logic o_timeout_c
);

    logic [1:0]       r_sync;
    logic             r_lrck_d;
    logic [CNT_W-1:0] r_wd_cnt;
    logic             w_edge;

    assign w_edge      = r_sync[1] ^ r_lrck_d;
    assign o_timeout_c = i_en && !w_edge && (r_wd_cnt == CNT_W'(LRCK_TO_CYC - 1));

    // Bring the asynchronous LRCK into the MCLK domain and keep one old sample
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync   <= 2'b00;
            r_lrck_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], i_lrck};
            r_lrck_d <= r_sync[1];
        end
    end

    // Quiet-time counter: cleared by any LRCK edge, when disabled, or on firing
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wd_cnt <= '0;
        end else if (!i_en || w_edge || o_timeout_c) begin
            r_wd_cnt <= '0;
        end else if (r_wd_cnt != {CNT_W{1'b1}}) begin
            r_wd_cnt <= r_wd_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/codec_init_sequencer.sv
// Bring-up sequencer for the ES7243E ADC / ES8156 DAC audio path.
// Holds the config engines in reset, starts ADC then DAC configuration with
// timeouts and retries, waits a settle period, then enables the I2S datapath.
// Optional feature macro: LRCK_WATCHDOG_EN (restart on loss of ADC LRCK in RUN).
module codec_init_sequencer
    import codec_seq_pkg::*;
#(
    parameter int unsigned PWRUP_CYC   = DEF_PWRUP_CYC,
    parameter int unsigned CFG_TO_CYC  = DEF_CFG_TO_CYC,
    parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int unsigned LRCK_TO_CYC = DEF_LRCK_TO_CYC,
    parameter int unsigned MAX_RETRY   = DEF_MAX_RETRY,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic               i_clk_12M,
    input  logic               i_rst,
    input  logic               i_reinit_req,
    output logic               o_cfg_rstn,
    output logic               o_adc_cfg_start,
    input  logic               i_adc_cfg_done,
    output logic               o_dac_cfg_start,
    input  logic               i_dac_cfg_done,
    input  logic               i_adc_lrck,
    output logic               o_stream_en,
    output logic               o_mute,
    output logic               o_init_err,
    output logic [RETRY_W-1:0] o_retry_cnt,
    output logic [STATE_W-1:0] o_state
);

    localparam logic [CNT_W-1:0] PWRUP_LAST  = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] CFG_TO_LAST = CNT_W'(CFG_TO_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMER_MAX   = {CNT_W{1'b1}};

    seq_state_t         r_state;
    logic [CNT_W-1:0]   r_timer;
    logic               r_cfg_rstn;
    logic               r_adc_start;
    logic               r_dac_start;
    logic               r_stream_en;
    logic               r_mute;
    logic               r_init_err;
    logic [RETRY_W-1:0] r_retry_cnt;
    // Failure counts per stage; DAC failures survive the ADC re-run after a DAC retry
    logic [RETRY_W-1:0] r_adc_fails;
    logic [RETRY_W-1:0] r_dac_fails;
    logic [RETRY_W-1:0] r_wd_fails;
    logic               w_wd_fire;
    logic               w_run;

    assign w_run = (r_state == ST_RUN);

`ifdef LRCK_WATCHDOG_EN
    lrck_activity_mon #(
        .CNT_W       (CNT_W),
        .LRCK_TO_CYC (LRCK_TO_CYC)
    ) u_lrck_mon (
        .i_clk       (i_clk_12M),
        .i_rst       (i_rst),
        .i_en        (w_run),
        .i_lrck      (i_adc_lrck),
        .o_timeout_c (w_wd_fire)
    );
`else
    // Without the watchdog, LRCK is not observed and RUN only ends on reinit/reset
    logic [CNT_W:0] w_lrck_unused;
    assign w_lrck_unused = {i_adc_lrck, CNT_W'(LRCK_TO_CYC - 1)};
    assign w_wd_fire     = 1'b0 & w_run;
`endif

    // Sequencer state, timer and all registered outputs
    always_ff @(posedge i_clk_12M) begin
        if (i_rst) begin
            r_state     <= ST_HOLD;
            r_timer     <= '0;
            r_cfg_rstn  <= 1'b0;
            r_adc_start <= 1'b0;
            r_dac_start <= 1'b0;
            r_stream_en <= 1'b0;
            r_mute      <= 1'b1;
            r_init_err  <= 1'b0;
            r_retry_cnt <= '0;
            r_adc_fails <= '0;
            r_dac_fails <= '0;
            r_wd_fails  <= '0;
        end else if (i_reinit_req) begin
            r_state     <= ST_HOLD;
            r_timer     <= '0;
            r_cfg_rstn  <= 1'b0;
            r_adc_start <= 1'b0;
            r_dac_start <= 1'b0;
            r_stream_en <= 1'b0;
            r_mute      <= 1'b1;
            r_init_err  <= 1'b0;
            r_retry_cnt <= '0;
            r_adc_fails <= '0;
            r_dac_fails <= '0;
            r_wd_fails  <= '0;
        end else begin
            r_adc_start <= 1'b0;
            r_dac_start <= 1'b0;
            if (r_timer != TIMER_MAX) begin
                r_timer <= r_timer + CNT_W'(1);
            end

            case (r_state)
                ST_HOLD: begin
                    r_cfg_rstn  <= 1'b0;
                    r_stream_en <= 1'b0;
                    r_mute      <= 1'b1;
                    if (r_timer == PWRUP_LAST) begin
                        r_state     <= ST_ADC_CFG;
                        r_timer     <= '0;
                        r_cfg_rstn  <= 1'b1;
                        r_adc_start <= 1'b1;
                    end
                end

                ST_ADC_CFG: begin
                    if (i_adc_cfg_done) begin
                        r_state     <= ST_DAC_CFG;
                        r_timer     <= '0;
                        r_dac_start <= 1'b1;
                        r_retry_cnt <= '0;
                        r_adc_fails <= '0;
                    end else if (r_timer == CFG_TO_LAST) begin
                        r_timer    <= '0;
                        r_cfg_rstn <= 1'b0;
                        if (retry_left(r_adc_fails, MAX_RETRY)) begin
                            r_state     <= ST_HOLD;
                            r_adc_fails <= r_adc_fails + RETRY_W'(1);
                            r_retry_cnt <= r_adc_fails + RETRY_W'(1);
                        end else begin
                            r_state    <= ST_FAULT;
                            r_init_err <= 1'b1;
                        end
                    end
                end

                ST_DAC_CFG: begin
                    if (i_dac_cfg_done) begin
                        r_state     <= ST_SETTLE;
                        r_timer     <= '0;
                        r_retry_cnt <= '0;
                        r_dac_fails <= '0;
                    end else if (r_timer == CFG_TO_LAST) begin
                        r_timer    <= '0;
                        r_cfg_rstn <= 1'b0;
                        if (retry_left(r_dac_fails, MAX_RETRY)) begin
                            r_state     <= ST_HOLD;
                            r_dac_fails <= r_dac_fails + RETRY_W'(1);
                            r_retry_cnt <= r_dac_fails + RETRY_W'(1);
                        end else begin
                            r_state    <= ST_FAULT;
                            r_init_err <= 1'b1;
                        end
                    end
                end

                ST_SETTLE: begin
                    if (r_timer == SETTLE_LAST) begin
                        r_state     <= ST_RUN;
                        r_timer     <= '0;
                        r_stream_en <= 1'b1;
                        r_mute      <= 1'b0;
                    end
                end

                ST_RUN: begin
                    // Mute leads; stream_en drops one cycle later in the next state
                    if (w_wd_fire) begin
                        r_timer    <= '0;
                        r_mute     <= 1'b1;
                        r_cfg_rstn <= 1'b0;
                        if (retry_left(r_wd_fails, MAX_RETRY)) begin
                            r_state     <= ST_HOLD;
                            r_wd_fails  <= r_wd_fails + RETRY_W'(1);
                            r_retry_cnt <= r_retry_cnt + RETRY_W'(1);
                        end else begin
                            r_state    <= ST_FAULT;
                            r_init_err <= 1'b1;
                        end
                    end
                end

                ST_FAULT: begin
                    r_cfg_rstn  <= 1'b0;
                    r_stream_en <= 1'b0;
                    r_mute      <= 1'b1;
                    r_init_err  <= 1'b1;
                end

                default: begin
                    r_state     <= ST_HOLD;
                    r_timer     <= '0;
                    r_cfg_rstn  <= 1'b0;
                    r_stream_en <= 1'b0;
                    r_mute      <= 1'b1;
                end
            endcase
        end
    end

    assign o_cfg_rstn      = r_cfg_rstn;
    assign o_adc_cfg_start = r_adc_start;
    assign o_dac_cfg_start = r_dac_start;
    assign o_stream_en     = r_stream_en;
    assign o_mute          = r_mute;
    assign o_init_err      = r_init_err;
    assign o_retry_cnt     = r_retry_cnt;
    assign o_state         = r_state;

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Self-checking bench for codec_init_sequencer with shortened timing.
module tb_codec_init_sequencer;

    localparam int PWRUP   = 64;
    localparam int CFG_TO  = 1000;
    localparam int SETTLE  = 200;
    localparam int LRCK_TO = 512;
    localparam int MAXR    = 3;
    localparam int LIMIT   = 4000;

    localparam logic [2:0] S_HOLD = 3'd0, S_ADC = 3'd1, S_DAC = 3'd2,
                           S_SETTLE = 3'd3, S_RUN = 3'd4, S_FAULT = 3'd5;

    logic       clk;
    logic       rst, reinit, adc_done, dac_done, lrck;
    logic       cfg_rstn, adc_start, dac_start, stream_en, mute, init_err;
    logic [1:0] retry;
    logic [2:0] state;

    int checks = 0, failures = 0;
    // Config-engine responder: done rises 'lat' cycles after the start pulse, -1 = never
    int adc_lat = 10, dac_lat = 10, a_cnt = -1, d_cnt = -1;
    int adc_starts = 0, dac_starts = 0, bad_start = 0;

    codec_init_sequencer #(
        .PWRUP_CYC(PWRUP), .CFG_TO_CYC(CFG_TO), .SETTLE_CYC(SETTLE),
        .LRCK_TO_CYC(LRCK_TO), .MAX_RETRY(MAXR), .CNT_W(20)
    ) dut (
        .i_clk_12M(clk), .i_rst(rst), .i_reinit_req(reinit),
        .o_cfg_rstn(cfg_rstn), .o_adc_cfg_start(adc_start), .i_adc_cfg_done(adc_done),
        .o_dac_cfg_start(dac_start), .i_dac_cfg_done(dac_done), .i_adc_lrck(lrck),
        .o_stream_en(stream_en), .o_mute(mute), .o_init_err(init_err),
        .o_retry_cnt(retry), .o_state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the two reg_config engines
    always @(negedge clk) begin
        if (adc_start) begin adc_starts++; if (!cfg_rstn) bad_start++; a_cnt = adc_lat; end
        if (dac_start) begin dac_starts++; if (!cfg_rstn) bad_start++; d_cnt = dac_lat; end
        if (a_cnt == 0) begin adc_done = 1'b1; a_cnt = -1; end else if (a_cnt > 0) a_cnt--;
        if (d_cnt == 0) begin dac_done = 1'b1; d_cnt = -1; end else if (d_cnt > 0) d_cnt--;
        if (!cfg_rstn) begin adc_done = 1'b0; dac_done = 1'b0; a_cnt = -1; d_cnt = -1; end
    end

    // Count consecutive cycles spent in state st, starting at the current negedge
    task automatic measure(input logic [2:0] st, output int n);
        n = 0;
        while (state == st && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic pulse_reinit();
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
    endtask

    // Full bring-up from the first HOLD cycle to the first RUN cycle
    task automatic run_sequence(input int la, input int ld);
        int n, sa, sd;
        adc_lat = la; dac_lat = ld; sa = adc_starts; sd = dac_starts;
        measure(S_HOLD, n);
        checks++; if (n !== PWRUP) begin failures++; $display("FAIL hold_len: got %0d expected %0d", n, PWRUP); end
        checks++; if ({cfg_rstn, adc_start, state} !== {2'b11, S_ADC}) begin failures++;
            $display("FAIL adc_entry: cfg_rstn=%0b start=%0b state=%0d expected 1 1 %0d", cfg_rstn, adc_start, state, S_ADC); end
        measure(S_ADC, n);
        checks++; if (n !== la + 1) begin failures++; $display("FAIL adc_len: got %0d expected %0d", n, la + 1); end
        checks++; if ({dac_start, retry, state} !== {1'b1, 2'd0, S_DAC}) begin failures++;
            $display("FAIL dac_entry: start=%0b retry=%0d state=%0d expected 1 0 %0d", dac_start, retry, state, S_DAC); end
        measure(S_DAC, n);
        checks++; if (n !== ld + 1) begin failures++; $display("FAIL dac_len: got %0d expected %0d", n, ld + 1); end
        checks++; if ({stream_en, mute} !== 2'b01) begin failures++;
            $display("FAIL settle_muted: stream_en=%0b mute=%0b expected 0 1", stream_en, mute); end
        measure(S_SETTLE, n);
        checks++; if (n !== SETTLE) begin failures++; $display("FAIL settle_len: got %0d expected %0d", n, SETTLE); end
        checks++; if ({state, stream_en, mute, retry} !== {S_RUN, 2'b10, 2'd0}) begin failures++;
            $display("FAIL run_entry: state=%0d stream_en=%0b mute=%0b retry=%0d expected %0d 1 0 0", state, stream_en, mute, retry, S_RUN); end
        checks++; if ((adc_starts - sa) !== 1 || (dac_starts - sd) !== 1) begin failures++;
            $display("FAIL start_pulses: adc=%0d dac=%0d expected 1 1", adc_starts - sa, dac_starts - sd); end
    endtask

    task automatic test_reset();
        rst = 1'b1; reinit = 1'b0; adc_done = 1'b0; dac_done = 1'b0; lrck = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if ({cfg_rstn, adc_start, dac_start, stream_en, mute, init_err} !== 6'b000010) begin failures++;
            $display("FAIL reset_outputs: got %06b expected 000010", {cfg_rstn, adc_start, dac_start, stream_en, mute, init_err}); end
        checks++; if ({state, retry} !== {S_HOLD, 2'd0}) begin failures++;
            $display("FAIL reset_state: state=%0d retry=%0d expected 0 0", state, retry); end
        rst = 1'b0;
    endtask

    task automatic test_powerup();
        run_sequence(100, 100);
    endtask

    task automatic test_midrun_reinit();
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(1, 60)) @(negedge clk);
            checks++; if (state !== S_RUN) begin failures++; $display("FAIL run_stays: state=%0d expected %0d", state, S_RUN); end
            pulse_reinit();
            checks++; if ({mute, stream_en, cfg_rstn, state} !== {3'b100, S_HOLD}) begin failures++;
                $display("FAIL reinit_exit: mute=%0b stream_en=%0b cfg_rstn=%0b state=%0d expected 1 0 0 0", mute, stream_en, cfg_rstn, state); end
            run_sequence(int'($urandom_range(0, 300)), int'($urandom_range(0, 300)));
        end
    endtask

    task automatic test_coincident();
        int n;
        // Done in the very timeout cycle wins
        pulse_reinit();
        run_sequence(CFG_TO - 1, CFG_TO - 1);
        // Done one cycle too late: timeout and retry
        pulse_reinit();
        adc_lat = CFG_TO;
        measure(S_HOLD, n);
        measure(S_ADC, n);
        checks++; if (n !== CFG_TO) begin failures++; $display("FAIL late_adc_len: got %0d expected %0d", n, CFG_TO); end
        checks++; if ({state, retry, cfg_rstn} !== {S_HOLD, 2'd1, 1'b0}) begin failures++;
            $display("FAIL late_adc_retry: state=%0d retry=%0d cfg_rstn=%0b expected 0 1 0", state, retry, cfg_rstn); end
        run_sequence(int'($urandom_range(0, 100)), int'($urandom_range(0, 100)));
    endtask

    task automatic test_dac_retry();
        int n;
        pulse_reinit();
        adc_lat = 5; dac_lat = -1;
        measure(S_HOLD, n);
        measure(S_ADC, n);
        measure(S_DAC, n);
        checks++; if (n !== CFG_TO) begin failures++; $display("FAIL dac_timeout_len: got %0d expected %0d", n, CFG_TO); end
        checks++; if ({state, retry, cfg_rstn} !== {S_HOLD, 2'd1, 1'b0}) begin failures++;
            $display("FAIL dac_retry: state=%0d retry=%0d cfg_rstn=%0b expected 0 1 0", state, retry, cfg_rstn); end
        run_sequence(int'($urandom_range(0, 100)), int'($urandom_range(0, 100)));
    endtask

    task automatic test_adc_timeout();
        int n;
        test_reset();
        adc_lat = -1;
        for (int r = 0; r < MAXR; r++) begin
            checks++; if (retry !== 2'(r)) begin failures++; $display("FAIL hold_retry: got %0d expected %0d", retry, r); end
            measure(S_HOLD, n);
            checks++; if (n !== PWRUP) begin failures++; $display("FAIL retry_hold_len: got %0d expected %0d", n, PWRUP); end
            measure(S_ADC, n);
            checks++; if (n !== CFG_TO) begin failures++; $display("FAIL adc_timeout_len: got %0d expected %0d", n, CFG_TO); end
        end
        checks++; if ({state, init_err, cfg_rstn, mute, stream_en} !== {S_FAULT, 4'b1010}) begin failures++;
            $display("FAIL fault_entry: state=%0d err=%0b cfg_rstn=%0b mute=%0b stream_en=%0b expected 5 1 0 1 0", state, init_err, cfg_rstn, mute, stream_en); end
    endtask

    task automatic test_recovery();
        repeat (20) @(negedge clk);
        checks++; if ({state, init_err} !== {S_FAULT, 1'b1}) begin failures++;
            $display("FAIL fault_sticky: state=%0d err=%0b expected 5 1", state, init_err); end
        pulse_reinit();
        checks++; if ({state, init_err, retry, mute} !== {S_HOLD, 1'b0, 2'd0, 1'b1}) begin failures++;
            $display("FAIL recovery: state=%0d err=%0b retry=%0d mute=%0b expected 0 0 0 1", state, init_err, retry, mute); end
        run_sequence(int'($urandom_range(0, 200)), int'($urandom_range(0, 200)));
    endtask

`ifdef LRCK_WATCHDOG_EN
    task automatic test_watchdog();
        int n;
        // 48 kHz LRCK: one toggle every 128 MCLK cycles
        for (int k = 0; k < 12; k++) begin
            repeat (128) @(negedge clk);
            lrck = ~lrck;
        end
        checks++; if (state !== S_RUN) begin failures++; $display("FAIL wd_active_run: state=%0d expected %0d", state, S_RUN); end
        measure(S_RUN, n);
        checks++; if (n < LRCK_TO || n > LRCK_TO + 6) begin failures++;
            $display("FAIL wd_latency: got %0d expected %0d..%0d", n, LRCK_TO, LRCK_TO + 6); end
        checks++; if ({state, mute, stream_en, retry} !== {S_HOLD, 2'b11, 2'd1}) begin failures++;
            $display("FAIL wd_mute_first: state=%0d mute=%0b stream_en=%0b retry=%0d expected 0 1 1 1", state, mute, stream_en, retry); end
        @(negedge clk);
        checks++; if ({mute, stream_en} !== 2'b10) begin failures++;
            $display("FAIL wd_stream_drop: mute=%0b stream_en=%0b expected 1 0", mute, stream_en); end
    endtask
`else
    task automatic test_run_persists();
        repeat (LRCK_TO + 200) @(negedge clk);
        checks++; if ({state, stream_en, mute} !== {S_RUN, 2'b10}) begin failures++;
            $display("FAIL run_persists: state=%0d stream_en=%0b mute=%0b expected 4 1 0", state, stream_en, mute); end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_powerup();
        test_midrun_reinit();
        test_coincident();
        test_dac_retry();
        test_adc_timeout();
        test_recovery();
`ifdef LRCK_WATCHDOG_EN
        test_watchdog();
`else
        test_run_persists();
`endif
        checks++; if (bad_start !== 0) begin failures++; $display("FAIL start_in_reset: got %0d expected 0", bad_start); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL global_timeout: simulation did not complete, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
